// File: rtl/charlieplex_scanner.sv
// Charlieplexed 7-pin LED scanner with a Wishbone classic register file.
// Each row drives its own pin high and sinks the lit columns on the remaining six pins.
module charlieplex_scanner #(
    parameter int unsigned TICKS_PER_ROW = 1024,
    parameter int unsigned BLANK_TICKS   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wb_stb,
    input  logic       wb_we,
    input  logic [2:0] wb_addr,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack,
    output logic [6:0] cxscreen_o,
    output logic [6:0] cxscreen_oe,
    output logic       frame_start
);

    localparam logic [15:0] DriveLast = 16'(TICKS_PER_ROW - 1);
    localparam logic [15:0] BlankLast = 16'(BLANK_TICKS - 1);
    localparam logic [2:0]  LastRow   = 3'd6;
    localparam logic [2:0]  CtrlAddr  = 3'd7;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scanState_e;

    logic [5:0] fb_q [7];
    logic       enable_q;
    logic       ack_q;
    logic [7:0] datOut_q;

    scanState_e state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [15:0] tick_q, tick_d;
    logic [5:0]  line_q, line_d;

    logic       busStart;
    logic [7:0] readData;
    logic [5:0] rowFb;

    assign busStart = wb_stb && !ack_q;

    always_comb begin
        readData = 8'h00;
        if (wb_addr == CtrlAddr) begin
            readData = {7'b0, enable_q};
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (wb_addr == 3'(i)) begin
                    readData = {2'b00, fb_q[i]};
                end
            end
        end
    end

    // A held strobe alternates ack on/off because a new transfer only starts while ack is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            datOut_q <= 8'h00;
            enable_q <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                fb_q[i] <= 6'd0;
            end
        end else begin
            ack_q    <= busStart;
            datOut_q <= (busStart && !wb_we) ? readData : 8'h00;
            if (busStart && wb_we) begin
                if (wb_addr == CtrlAddr) begin
                    enable_q <= wb_dat_i[0];
                end
                for (int i = 0; i < 7; i++) begin
                    if (wb_addr == 3'(i)) begin
                        fb_q[i] <= wb_dat_i[5:0];
                    end
                end
            end
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = datOut_q;

    always_comb begin
        rowFb = 6'd0;
        for (int i = 0; i < 7; i++) begin
            if (row_q == 3'(i)) begin
                rowFb = fb_q[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
            row_q   <= 3'd0;
            tick_q  <= 16'd0;
            line_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tick_q  <= tick_d;
            line_q  <= line_d;
        end
    end

    // The line is latched from the framebuffer as it stood before this edge, so a
    // write landing on the BLANK->DRIVE edge only shows up on the next visit.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tick_d  = tick_q;
        line_d  = line_q;
        if (!enable_q) begin
            state_d = BLANK;
            row_d   = 3'd0;
            tick_d  = 16'd0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (tick_q == BlankLast) begin
                        state_d = DRIVE;
                        tick_d  = 16'd0;
                        line_d  = rowFb;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                DRIVE: begin
                    if (tick_q == DriveLast) begin
                        state_d = BLANK;
                        tick_d  = 16'd0;
                        row_d   = (row_q == LastRow) ? 3'd0 : row_q + 3'd1;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                default: state_d = BLANK;
            endcase
        end
    end

    logic [6:0] rowBit;
    logic [6:0] lowMask;
    logic [6:0] highMask;
    logic       driving;

    // Line bits below the row map straight onto pins; bits at or above it skip the row pin.
    always_comb begin
        rowBit   = 7'd1 << row_q;
        lowMask  = rowBit - 7'd1;
        highMask = ~(lowMask | rowBit);
        driving  = enable_q && (state_q == DRIVE);
        cxscreen_o  = 7'd0;
        cxscreen_oe = 7'd0;
        frame_start = 1'b0;
        if (driving) begin
            cxscreen_o  = rowBit;
            cxscreen_oe = rowBit | ({1'b0, line_q} & lowMask) | ({line_q, 1'b0} & highMask);
            frame_start = (row_q == 3'd0) && (tick_q == 16'd0);
        end
    end

endmodule

// File: doc/charlieplex_scanner.md
CHARLIEPLEX_SCANNER -- requirements
Module: charlieplex_scanner

Interface
REQ-001 SHALL have parameter TICKS_PER_ROW, default 1024, meaning clock cycles each row is driven (legal range 1..65535).
REQ-002 SHALL have parameter BLANK_TICKS, default 16, meaning clock cycles all pins are released between rows (legal range 1..65535).
REQ-003 SHALL have port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wb_stb  input  1  Wishbone classic strobe (cycle and strobe combined).
REQ-006 SHALL have port wb_we  input  1  write enable; 1 = write, 0 = read.
REQ-007 SHALL have port wb_addr  input  3  register address.
REQ-008 SHALL have port wb_dat_i  input  8  write data.
REQ-009 SHALL have port wb_dat_o  output  8  read data, valid while wb_ack = 1.
REQ-010 SHALL have port wb_ack  output  1  single-cycle transfer acknowledge.
REQ-011 SHALL have port cxscreen_o  output  7  pin output levels.
REQ-012 SHALL have port cxscreen_oe  output  7  pin output enables; 0 = high-impedance.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse on entry to row 0 DRIVE.

Function
REQ-014 SHALL hold framebuffer fb[0..6], 6 bits each; addr 0-6 write fb[addr] <= wb_dat_i[5:0], read returns {2'b00, fb[addr]}.
REQ-015 SHALL treat addr 7 as CTRL: bit0 = enable; read returns {7'b0, enable}; bits 7:1 ignored on write.
REQ-016 SHALL raise wb_ack on the edge after a cycle with wb_stb=1 and wb_ack=0, hold it exactly one cycle; a held wb_stb produces ack every second cycle.
REQ-017 SHALL commit writes and load wb_dat_o on the same edge that raises wb_ack; wb_dat_o = 0 when wb_ack = 0.
REQ-018 SHALL implement states BLANK and DRIVE, a 3-bit row counter (0..6) and a 16-bit tick counter.
REQ-019 SHALL in BLANK drive cxscreen_oe = 0, cxscreen_o = 0; after BLANK_TICKS cycles go to DRIVE, reset tick counter, latch line <= fb[row].
REQ-020 SHALL in DRIVE for row r set oe[r]=1, o[r]=1; for pin c != r with j = (c<r ? c : c-1): oe[c]=line[j], o[c]=0.
REQ-021 SHALL after TICKS_PER_ROW DRIVE cycles go to BLANK, row <= row+1, wrapping 6 -> 0.
REQ-022 SHALL pulse frame_start for exactly the first DRIVE cycle of row 0.
REQ-023 SHALL latch the pre-write fb value when a write to fb[row] lands on the BLANK->DRIVE edge; writes during DRIVE affect the next visit only.
REQ-024 SHALL while enable = 0 hold state BLANK, row 0, tick counter 0, all outputs 0 except Wishbone.
REQ-025 SHALL on enable 1 -> 0 mid-DRIVE release all pins on the very next cycle and return to BLANK/row 0; on 0 -> 1 start with a full BLANK_TICKS blank of row 0.
REQ-026 SHALL derive cxscreen_o/oe/frame_start only from registered state (no combinational path from Wishbone inputs).
REQ-027 SHALL never enable a pin with o=1 other than pin row, so at most one pin drives high.

Reset
REQ-028 SHALL on reset force fb[*]=0, enable=0, state BLANK, row=0, counters=0, line=0, wb_ack=0, wb_dat_o=0, cxscreen_o=0, cxscreen_oe=0, frame_start=0, immediately and independent of clock.
REQ-029 SHALL, on reset asserted mid-transaction, drop wb_ack and discard the pending write.

Verification (TICKS_PER_ROW=4, BLANK_TICKS=2)
REQ-030 Write fb[2]=0x2D, read addr 2 -> wb_ack one cycle after stb, wb_dat_o=0x2D; read addr 7 after reset -> 0x00.
REQ-031 fb[0]=0x3F, enable=1 -> 2 cycles oe=0, then 4 cycles oe=0x7F, o=0x01, frame_start high first DRIVE cycle only, then 2 cycles oe=0.
REQ-032 fb[3]=0x15 (j=0,2,4 -> pins 0,2,5) -> row 3 DRIVE oe=0x2D, o=0x08; full frame = 7*6 = 42 cycles between frame_start pulses.
REQ-033 Clear enable during row 4 DRIVE -> next cycle oe=0; re-enable -> 2 blank cycles then row 0 DRIVE with frame_start.
REQ-034 Write fb[1]=0x01 on BLANK->DRIVE edge of row 1 with old fb[1]=0 -> row 1 oe=0x02; next frame row 1 oe=0x03.
REQ-035 Assert reset during row 5 DRIVE with wb_stb write pending -> outputs 0 asynchronously, fb unchanged to 0, enable=0, no ack.
